pool_feeder: RTL
================

Name: pool_feeder

Overview:
- Upstream stage of the 2x2 pooling unit.
- Streams a convolution feature map from the feature buffer as horizontal pixel pairs on data1/data2, and drives en_comp1/en_comp2 in the pattern the pooling unit's two comparators and 13-deep line buffer expect.
- After every odd row it pulses pool_done, then idles the pooling interface while the 13-word pooled-row writeback completes.
- One start produces one full pooled frame, with IMG_H/2 pool_done pulses.

Parameters:
- DATA_W, 8: pixel width.
- IMG_W, 26: feature-map width. Must be even; IMG_W/2 must equal the pooling line depth (13).
- IMG_H, 26: feature-map height. Must be even; an elaboration-time check fails otherwise.
- ADDR_W, 10: feature-buffer address width. Must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- WB_WAIT, 16: number of idle cycles after a pool_done pulse. Covers the pooling unit's IDLE->POOL_WB->DONE sequence, which is 16 cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle frame request; sampled only in IDLE.
- pool_type_in  in  1  0 = max, 1 = min; latched when start is accepted.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at frame end.
- rd_addr_a  out  ADDR_W  buffer read address, even column.
- rd_addr_b  out  ADDR_W  buffer read address, odd column.
- rd_data_a  in  DATA_W  synchronous read data, 1-cycle latency.
- rd_data_b  in  DATA_W  synchronous read data, 1-cycle latency.
- data1  out  DATA_W  pixel at even column (wired from rd_data_a).
- data2  out  DATA_W  pixel at odd column (wired from rd_data_b).
- pool_type  out  1  latched pool type.
- en_comp1  out  1  pair valid, every row.
- en_comp2  out  1  pair valid and current row is odd.
- pool_done  out  1  one-cycle pulse: pooled row complete.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; busy, done, en_comp1, en_comp2, pool_done, pool_type, rd_addr_a, rd_addr_b, and the row/column/wait counters all 0.
- IDLE:
  - start=1 latches pool_type_in, clears row and column, and enters FETCH next cycle.
  - start is ignored in every other state.
- FETCH, one pair per cycle:
  - rd_addr_a = row*IMG_W + 2*col; rd_addr_b = rd_addr_a + 1.
  - col counts 0..IMG_W/2-1.
  - At the last col: col wraps to 0 and row increments.
    - If the row just fetched is even, FETCH continues with no bubble.
    - If it is odd, go to DRAIN.
- Valid pipeline:
  - The "pair issued" flag is registered once, so en_comp1 is high the cycle after each address issue, aligned with rd_data.
  - en_comp2 = the registered flag AND the registered row-odd bit.
  - Both are 0 outside the cycle following an address issue.
- DRAIN (1 cycle): the final en_comp1/en_comp2 of the odd row is emitted; no new address is issued.
- SYNC (1 cycle): pool_done=1; en_comp1=en_comp2=0.
- WAIT (WB_WAIT cycles):
  - All pooling-interface enables are 0.
  - When the counter expires: go to FIN if row==IMG_H, else FETCH.
- FIN (1 cycle): done=1, busy drops to 0, then return to IDLE.
- Address arithmetic is unsigned in ADDR_W; addresses hold their last value outside FETCH.
- Per pooled row the sequence is IMG_W fetch cycles + DRAIN + SYNC + WB_WAIT = 44 cycles at default parameters.
- Reset mid-frame: abandon immediately with no done pulse. The next start restarts from row 0.

Decomposition:
- Shared pool package: state encoding (IDLE, FETCH, DRAIN, SYNC, WAIT, FIN), POOL_MAX=0 and POOL_MIN=1 constants, and the default image dimensions. The pooling unit and this block both import it.
- No sub-module is required. Optionally, the address generator (row/col counters plus address adder) may be split out as pool_addr_gen.

Test Plan:
- Reset: hold rst=0 with start=1 -> all outputs 0, state IDLE; release -> no activity until a start edge.
- Single pooled row:
  - Buffer preloaded with pix[a]=a[7:0]; start.
  - Addresses 0/1, 2/3, .. 24/25, then 26/27 .. 50/51 on consecutive cycles.
  - en_comp1 high for 26 consecutive cycles, each one cycle after its address.
  - en_comp2 high only on the last 13 of those cycles; data1/data2 = 26/27 on the first of them.
  - pool_done pulses exactly 2 cycles after the last address issue (cycle 28).
- Full frame:
  - 13 pool_done pulses spaced 44 cycles apart.
  - done pulses at cycle 573 after start was sampled.
  - busy high over cycles 1..572.
- start held or re-pulsed while busy -> ignored; frame timing identical to the previous case; pool_type is unchanged when pool_type_in toggles mid-frame.
- Reset asserted during WAIT of row pair 5 -> outputs 0 immediately, no done pulse; a new start refetches address 0/1.
- pool_type_in=1 at start -> pool_type=1 for the whole frame and 0 again after reset.

Source files
------------

// File: rtl/pool_feeder_pkg.sv
// Shared definitions for the 2x2 pooling datapath: FSM state encoding,
// pool-type constants and default feature-map geometry.
// Imported by the pool feeder and by the pooling unit it drives.
package pool_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SYNC  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_FIN   = 3'd5
    } pool_state_e;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_MIN = 1'b1;

    localparam int POOL_DATA_W     = 8;
    localparam int POOL_IMG_W      = 26;
    localparam int POOL_IMG_H      = 26;
    localparam int POOL_ADDR_W     = 10;
    localparam int POOL_WB_WAIT    = 16;
    // Depth of the pooling unit's line buffer; one entry per pixel pair.
    localparam int POOL_LINE_DEPTH = 13;

endpackage

// File: rtl/pool_feeder.sv
// Purpose : streams a feature map as horizontal pixel pairs into the 2x2 pooling unit.
// Latency : pair data/enables appear 1 cycle after address issue; pool_done 2 cycles after the last odd-row issue.
// Backpr. : none; fixed schedule, with a WB_WAIT idle gap after each pooled row for writeback.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start, pool_type_in frame request (IDLE only) and pool type latched with it
//   busy, done          frame in progress / one-cycle end-of-frame pulse
//   rd_addr_a/b         even/odd column read addresses to the feature buffer
//   rd_data_a/b         buffer read data, one cycle after the address
//   data1/data2         pixel pair to the pooling comparators
//   pool_type           latched pool type (0 max, 1 min)
//   en_comp1/en_comp2   pair valid / pair valid on an odd row
//   pool_done           one-cycle pulse after each completed pooled row
module pool_feeder
    import pool_feeder_pkg::*;
#(
    parameter int DATA_W  = POOL_DATA_W,
    parameter int IMG_W   = POOL_IMG_W,
    parameter int IMG_H   = POOL_IMG_H,
    parameter int ADDR_W  = POOL_ADDR_W,
    parameter int WB_WAIT = POOL_WB_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pool_type_in,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic              pool_type,
    output logic              en_comp1,
    output logic              en_comp2,
    output logic              pool_done
);

    localparam int PAIRS  = IMG_W / 2;
    localparam int COL_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int ROW_W  = $clog2(IMG_H + 1);
    localparam int WAIT_W = (WB_WAIT > 1) ? $clog2(WB_WAIT) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(PAIRS - 1);
    localparam logic [ROW_W-1:0]  ROW_END   = ROW_W'(IMG_H);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WB_WAIT - 1);

    generate
        if ((IMG_H % 2) != 0) begin : g_bad_img_h
            $error("pool_feeder: IMG_H must be even");
        end
        if ((IMG_W % 2) != 0 || PAIRS != POOL_LINE_DEPTH) begin : g_bad_img_w
            $error("pool_feeder: IMG_W must be even and IMG_W/2 must match the pooling line depth");
        end
        if ((64'd1 << ADDR_W) < 64'(IMG_W * IMG_H)) begin : g_bad_addr_w
            $error("pool_feeder: ADDR_W too narrow for IMG_W*IMG_H");
        end
    endgenerate

    // Even-column address of pair (row, col); the odd column is always this + 1.
    function automatic logic [ADDR_W-1:0] pair_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(IMG_W) + (ADDR_W'(col) << 1);
    endfunction

    pool_state_e        state_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [ADDR_W-1:0]  rd_addr_a_q;
    logic [ADDR_W-1:0]  rd_addr_b_q;
    logic               vld_q;
    logic               odd_q;
    logic               busy_q;
    logic               done_q;
    logic               pool_done_q;
    logic               pool_type_q;

    logic [ROW_W-1:0]   row_d;
    logic [COL_W-1:0]   col_d;

    assign row_d = row_q + 1'b1;
    assign col_d = col_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            wait_q      <= '0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            vld_q       <= 1'b0;
            odd_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pool_done_q <= 1'b0;
            pool_type_q <= POOL_MAX;
        end else begin
            // The read port returns data one cycle after the address, so the
            // issue flag and its row parity are delayed by exactly one register.
            vld_q       <= (state_q == ST_FETCH);
            odd_q       <= row_q[0];
            done_q      <= 1'b0;
            pool_done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pool_type_q <= pool_type_in;
                        row_q       <= '0;
                        col_q       <= '0;
                        rd_addr_a_q <= '0;
                        rd_addr_b_q <= ADDR_W'(1);
                        busy_q      <= 1'b1;
                        state_q     <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (col_q == COL_LAST) begin
                        col_q <= '0;
                        row_q <= row_d;
                        if (row_q[0]) begin
                            // Odd row done: the pooled row is complete once the
                            // last pair drains out of the read pipeline.
                            state_q <= ST_DRAIN;
                        end else begin
                            rd_addr_a_q <= pair_addr(row_d, '0);
                            rd_addr_b_q <= pair_addr(row_d, '0) + 1'b1;
                        end
                    end else begin
                        col_q       <= col_d;
                        rd_addr_a_q <= pair_addr(row_q, col_d);
                        rd_addr_b_q <= pair_addr(row_q, col_d) + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    pool_done_q <= 1'b1;
                    state_q     <= ST_SYNC;
                end

                ST_SYNC: begin
                    wait_q  <= '0;
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        wait_q <= '0;
                        if (row_q == ROW_END) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_FIN;
                        end else begin
                            rd_addr_a_q <= pair_addr(row_q, '0);
                            rd_addr_b_q <= pair_addr(row_q, '0) + 1'b1;
                            state_q     <= ST_FETCH;
                        end
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end

                ST_FIN: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign data1     = rd_data_a;
    assign data2     = rd_data_b;
    assign pool_type = pool_type_q;
    assign en_comp1  = vld_q;
    assign en_comp2  = vld_q & odd_q;
    assign pool_done = pool_done_q;

endmodule
